// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline control: opcodes, control-bundle bit
// positions, control FSM states and source-register usage flags.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam int CTRL_W        = 12;
   localparam int CTRL_HALT     = 11;
   localparam int CTRL_REGDST   = 10;
   localparam int CTRL_ALUSRC   = 9;
   localparam int CTRL_MEMREAD  = 8;
   localparam int CTRL_MEMWRITE = 7;
   localparam int CTRL_MEMTOREG = 6;
   localparam int CTRL_REGWRITE = 5;
   localparam int CTRL_LOWER    = 4;
   localparam int CTRL_HIGHER   = 3;
   localparam int CTRL_BEN      = 2;
   localparam int CTRL_BR       = 1;
   localparam int CTRL_PCS      = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Which instruction fields name a register that is read in EX.
   typedef struct packed {
      logic rs;
      logic rt;
      logic rd;
   } src_use_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the 12-bit control bundle and the
// source-register usage flags for the instruction sitting in IF/ID.
module ctrl_decode
   import wisc_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic             i_valid,
   input  logic [OPC_W-1:0] i_opc,
   output ctrl_t            o_ctrl,
   output src_use_t         o_src
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      o_ctrl = '0;
      o_src  = '0;
      if (i_valid) begin
         case (i_opc)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
               o_ctrl[CTRL_REGDST]   = 1'b1;
               o_ctrl[CTRL_REGWRITE] = 1'b1;
               o_src.rs              = 1'b1;
               o_src.rt              = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
               o_ctrl[CTRL_REGDST]   = 1'b1;
               o_ctrl[CTRL_ALUSRC]   = 1'b1;
               o_ctrl[CTRL_REGWRITE] = 1'b1;
               o_src.rs              = 1'b1;
            end
            OP_LW: begin
               o_ctrl[CTRL_ALUSRC]   = 1'b1;
               o_ctrl[CTRL_MEMREAD]  = 1'b1;
               o_ctrl[CTRL_MEMTOREG] = 1'b1;
               o_ctrl[CTRL_REGWRITE] = 1'b1;
               o_src.rs              = 1'b1;
            end
            OP_SW: begin
               // The store data register travels in the rd field.
               o_ctrl[CTRL_ALUSRC]   = 1'b1;
               o_ctrl[CTRL_MEMWRITE] = 1'b1;
               o_src.rs              = 1'b1;
               o_src.rd              = 1'b1;
            end
            OP_LLB, OP_LHB: begin
               o_ctrl[CTRL_REGDST]   = 1'b1;
               o_ctrl[CTRL_ALUSRC]   = 1'b1;
               o_ctrl[CTRL_REGWRITE] = 1'b1;
               o_ctrl[CTRL_LOWER]    = (i_opc == OP_LLB);
               o_ctrl[CTRL_HIGHER]   = (i_opc == OP_LHB);
               o_src.rd              = 1'b1;
            end
            OP_B: begin
               o_ctrl[CTRL_BEN] = 1'b1;
            end
            OP_BR: begin
               o_ctrl[CTRL_BEN] = 1'b1;
               o_ctrl[CTRL_BR]  = 1'b1;
               o_src.rs         = 1'b1;
            end
            OP_PCS: begin
               o_ctrl[CTRL_REGWRITE] = 1'b1;
               o_ctrl[CTRL_PCS]      = 1'b1;
            end
            OP_HLT: begin
               o_ctrl[CTRL_HALT] = 1'b1;
            end
            default: begin
               o_ctrl = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// WISC pipeline control: owns the ID/EX control register, steers PC and IF/ID
// for load-use stalls, taken branches and memory freezes, and drains on HLT.
module pipe_ctrl_unit
   import wisc_pkg::*;
#(
   parameter int OPC_W   = 4,
   parameter int REG_AW  = 4,
   parameter int INSTR_W = 16,
   parameter int DRAIN   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [INSTR_W-1:0]  id_instr,
   input  logic                br_taken,
   input  logic                mem_busy,
   output logic [CTRL_W-1:0]   ex_ctrl,
   output logic [REG_AW-1:0]   ex_rd,
   output logic                pc_we,
   output logic                ifid_we,
   output logic                ifid_flush,
   output logic                halted
);

   localparam int         RD_MSB     = INSTR_W - OPC_W - 1;
   localparam int         RS_MSB     = RD_MSB - REG_AW;
   localparam int         RT_MSB     = RS_MSB - REG_AW;
   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN);

   logic [OPC_W-1:0]  w_opc;
   logic [REG_AW-1:0] w_rd, w_rs, w_rt, w_dec_rd;
   ctrl_t             w_dec_ctrl;
   src_use_t          w_src;
   logic              w_load_use, w_br;

   state_t            r_state, w_state_nx;
   logic [3:0]        r_cnt, w_cnt_nx;
   ctrl_t             r_ex_ctrl, w_ex_ctrl_nx;
   logic [REG_AW-1:0] r_ex_rd, w_ex_rd_nx;

   assign w_opc    = id_instr[INSTR_W-1 -: OPC_W];
   assign w_rd     = id_instr[RD_MSB -: REG_AW];
   assign w_rs     = id_instr[RS_MSB -: REG_AW];
   assign w_rt     = id_instr[RT_MSB -: REG_AW];
   assign w_dec_rd = id_valid ? w_rd : '0;

   ctrl_decode #(.OPC_W(OPC_W)) u_decode (
      .i_valid (id_valid),
      .i_opc   (w_opc),
      .o_ctrl  (w_dec_ctrl),
      .o_src   (w_src)
   );

   // Register 0 is hardwired zero, so a load into it can never create a hazard.
   assign w_load_use = r_ex_ctrl[CTRL_MEMREAD] && (r_ex_rd != '0) &&
                       ((w_src.rs && (w_rs == r_ex_rd)) ||
                        (w_src.rt && (w_rt == r_ex_rd)) ||
                        (w_src.rd && (w_rd == r_ex_rd)));

   assign w_br = br_taken && r_ex_ctrl[CTRL_BEN];

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_ex_ctrl_nx = r_ex_ctrl;
      w_ex_rd_nx   = r_ex_rd;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (!mem_busy) begin
               if (w_br) begin
                  pc_we        = 1'b1;
                  ifid_we      = 1'b1;
                  ifid_flush   = 1'b1;
                  w_ex_ctrl_nx = '0;
                  w_ex_rd_nx   = '0;
               end else if (w_load_use) begin
                  w_ex_ctrl_nx = '0;
                  w_ex_rd_nx   = '0;
               end else begin
                  w_ex_ctrl_nx = w_dec_ctrl;
                  w_ex_rd_nx   = w_dec_rd;
                  if (w_dec_ctrl[CTRL_HALT]) begin
                     w_state_nx = ST_DRAIN;
                     w_cnt_nx   = DRAIN_INIT;
                  end else begin
                     pc_we   = 1'b1;
                     ifid_we = 1'b1;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (!mem_busy) begin
               w_ex_ctrl_nx = '0;
               w_ex_rd_nx   = '0;
               if (r_cnt <= 4'd1) begin
                  w_state_nx = ST_HALTED;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = r_cnt - 4'd1;
               end
            end
         end
         ST_HALTED: begin
            w_ex_ctrl_nx = '0;
            w_ex_rd_nx   = '0;
         end
         default: begin
            w_state_nx = ST_RUN;
         end
      endcase
      // Reset overrides steering so IF/ID is flushed while the pipe restarts.
      if (rst) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_state   <= ST_RUN;
         r_cnt     <= '0;
         r_ex_ctrl <= '0;
         r_ex_rd   <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_ex_ctrl <= w_ex_ctrl_nx;
         r_ex_rd   <= w_ex_rd_nx;
      end
   end

   assign ex_ctrl = r_ex_ctrl;
   assign ex_rd   = r_ex_rd;
   assign halted  = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected ID/EX contents are queued when
// stimulus is driven and compared after the clock edge that loads them.
module tb_pipe_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst, id_valid, br_taken, mem_busy;
   logic [15:0] id_instr;
   logic [11:0] ex_ctrl;
   logic [3:0]  ex_rd;
   logic        pc_we, ifid_we, ifid_flush, halted;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string tag;
      int    ctrl;
      int    rd;
      int    halt;
   } exp_t;

   exp_t sb[$];

   // Expected control bundle per opcode 0..F (halt,RegDst,ALUSrc,MemRead,MemWrite,
   // MemtoReg,RegWrite,Lower,Higher,BEn,Br,PCS).
   int dec_tab [16] = '{'h420, 'h420, 'h420, 'h420, 'h620, 'h620, 'h620, 'h420,
                        'h360, 'h280, 'h630, 'h628, 'h004, 'h006, 'h021, 'h800};

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.OPC_W(4), .REG_AW(4), .INSTR_W(16), .DRAIN(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .br_taken   (br_taken),
      .mem_busy   (mem_busy),
      .ex_ctrl    (ex_ctrl),
      .ex_rd      (ex_rd),
      .pc_we      (pc_we),
      .ifid_we    (ifid_we),
      .ifid_flush (ifid_flush),
      .halted     (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== 32'(exp)) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
      return {op, rd, rs, rt};
   endfunction

   // One clock: drive inputs, check steering at negedge (-1 skips), queue the
   // expected ID/EX contents, then pop and compare after the edge.
   task automatic cyc(input string tag, input int r, input int v, input logic [15:0] ins,
                      input int br, input int busy, input int e_pc, input int e_ifid,
                      input int e_fl, input int e_ctrl, input int e_rd, input int e_halt);
      exp_t e;
      rst      = r[0];
      id_valid = v[0];
      id_instr = ins;
      br_taken = br[0];
      mem_busy = busy[0];
      @(negedge clk);
      if (e_pc >= 0)   check({tag, ".pc_we"}, 32'(pc_we), e_pc);
      if (e_ifid >= 0) check({tag, ".ifid_we"}, 32'(ifid_we), e_ifid);
      if (e_fl >= 0)   check({tag, ".ifid_flush"}, 32'(ifid_flush), e_fl);
      e.tag  = tag;
      e.ctrl = e_ctrl;
      e.rd   = e_rd;
      e.halt = e_halt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".ex_ctrl"}, 32'(ex_ctrl), e.ctrl);
      if (e.rd >= 0)   check({e.tag, ".ex_rd"}, 32'(ex_rd), e.rd);
      if (e.halt >= 0) check({e.tag, ".halted"}, 32'(halted), e.halt);
   endtask

   logic [15:0] add_i, hlt_i;

   initial begin
      rst      = 1'b1;
      id_valid = 1'b0;
      id_instr = '0;
      br_taken = 1'b0;
      mem_busy = 1'b0;
      add_i    = mk(4'h0, 4'd1, 4'd2, 4'd3);
      hlt_i    = mk(4'hF, 4'd0, 4'd0, 4'd0);

      // Reset: steering forced, ID/EX cleared even with a valid instruction present.
      cyc("rst0", 1, 1, add_i, 0, 0, 0, 0, 1, 'h000, 0, 0);
      cyc("rst1", 1, 0, 16'h0, 0, 0, 0, 0, 1, 'h000, 0, 0);

      // Decode sweep of all non-halting opcodes, rd field = opcode.
      for (int op = 0; op < 15; op++)
         cyc($sformatf("dec%0d", op), 0, 1, mk(4'(op), 4'(op), 4'd1, 4'd2), 0, 0,
             1, 1, 0, dec_tab[op], op, 0);
      cyc("invalid", 0, 0, mk(4'h8, 4'd3, 4'd3, 4'd3), 0, 0, 1, 1, 0, 'h000, 0, 0);

      // Load-use through rs, then through the rd field (LLB), then B which reads nothing.
      cyc("lw3_a",    0, 1, mk(4'h8, 4'd3, 4'd1, 4'd0), 0, 0, 1, 1, 0, 'h360, 3, 0);
      cyc("lu_rs",    0, 1, mk(4'h0, 4'd1, 4'd3, 4'd2), 0, 0, 0, 0, 0, 'h000, 0, 0);
      cyc("lu_rs_go", 0, 1, mk(4'h0, 4'd1, 4'd3, 4'd2), 0, 0, 1, 1, 0, 'h420, 1, 0);
      cyc("lw3_b",    0, 1, mk(4'h8, 4'd3, 4'd1, 4'd0), 0, 0, 1, 1, 0, 'h360, 3, 0);
      cyc("lu_rd",    0, 1, mk(4'hA, 4'd3, 4'd0, 4'd0), 0, 0, 0, 0, 0, 'h000, 0, 0);
      cyc("lu_rd_go", 0, 1, mk(4'hA, 4'd3, 4'd0, 4'd0), 0, 0, 1, 1, 0, 'h630, 3, 0);
      cyc("lw3_c",    0, 1, mk(4'h8, 4'd3, 4'd1, 4'd0), 0, 0, 1, 1, 0, 'h360, 3, 0);
      cyc("b_nouse",  0, 1, mk(4'hC, 4'd3, 4'd3, 4'd3), 0, 0, 1, 1, 0, 'h004, 3, 0);
      cyc("lw0",      0, 1, mk(4'h8, 4'd0, 4'd1, 4'd0), 0, 0, 1, 1, 0, 'h360, 0, 0);
      cyc("lu_r0",    0, 1, mk(4'h0, 4'd1, 4'd0, 4'd2), 0, 0, 1, 1, 0, 'h420, 1, 0);

      // Taken branch squashes; br_taken without a branch in ID/EX is ignored.
      cyc("b",        0, 1, mk(4'hC, 4'd0, 4'd0, 4'd0), 0, 0, 1, 1, 0, 'h004, 0, 0);
      cyc("br_taken", 0, 1, add_i, 1, 0, 1, -1, 1, 'h000, 0, 0);
      cyc("add",      0, 1, add_i, 0, 0, 1, 1, 0, 'h420, 1, 0);
      cyc("br_noben", 0, 1, add_i, 1, 0, 1, 1, 0, 'h420, 1, 0);

      // mem_busy beats br_taken; branch honoured once busy drops.
      cyc("b2",       0, 1, mk(4'hC, 4'd5, 4'd0, 4'd0), 0, 0, 1, 1, 0, 'h004, 5, 0);
      cyc("busy_br",  0, 1, add_i, 1, 1, 0, 0, 0, 'h004, 5, 0);
      cyc("br_after", 0, 1, add_i, 1, 0, 1, -1, 1, 'h000, 0, 0);

      // HLT with one busy cycle mid-drain: halted after the 4th edge.
      cyc("hlt",      0, 1, hlt_i, 0, 0, 0, 0, 0, 'h800, 0, 0);
      cyc("drain1",   0, 1, hlt_i, 1, 0, 0, 0, 0, 'h000, 0, 0);
      cyc("drain2",   0, 1, hlt_i, 0, 1, 0, 0, 0, 'h000, 0, 0);
      cyc("drain3",   0, 1, hlt_i, 0, 0, 0, 0, 0, 'h000, 0, 0);
      cyc("drain4",   0, 1, hlt_i, 0, 0, 0, 0, 0, 'h000, 0, 1);
      cyc("halted",   0, 1, add_i, 0, 0, 0, 0, 0, 'h000, 0, 1);

      // Reset leaves HALTED; then reset mid-drain returns to a clean RUN.
      cyc("rst_h",    1, 1, add_i, 0, 0, 0, 0, 1, 'h000, 0, 0);
      cyc("post_h",   0, 1, add_i, 0, 0, 1, 1, 0, 'h420, 1, 0);
      cyc("hlt2",     0, 1, hlt_i, 0, 0, 0, 0, 0, 'h800, 0, 0);
      cyc("drain_a",  0, 1, hlt_i, 0, 0, 0, 0, 0, 'h000, 0, 0);
      cyc("rst_d",    1, 1, hlt_i, 0, 0, 0, 0, 1, 'h000, 0, 0);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("post_d%0d", i), 0, 1, add_i, 0, 0, 1, 1, 0, 'h420, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
